sm_divider: RTL

SM_DIVIDER -- requirements
Module: sm_divider

---
 rtl/sm_divider.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sm_divider.sv
// ---------------------------------------------------------------------------
// sm_divider
//   Sign-magnitude restoring divider. It divides a 21-bit sign-magnitude
//   dividend (multiplier product format) by an 11-bit sign-magnitude divisor.
//   The divider produces one quotient bit per clock, MSB first, over 20 RUN
//   cycles. A zero divisor magnitude skips RUN and finishes on the start edge.
//
//   Optional feature (build macro):
//     DIV_SATURATE_EN  - if defined, an overflowing quotient magnitude is
//                        clamped to 10'h3FF. If undefined, the quotient
//                        magnitude is the low 10 raw bits (truncated).
//                        The overflow flag and the Remainder are the same
//                        in both builds.
//
//   Ports
//     clk          in   1   rising-edge clock
//     rst          in   1   synchronous active-high reset
//     start        in   1   operation request, sampled only in IDLE
//     Dividend     in  21   bit 20 sign, bits 19:0 magnitude
//     Divisor      in  11   bit 10 sign, bits 9:0 magnitude
//     Quotient     out 11   bit 10 sign, bits 9:0 magnitude (registered)
//     Remainder    out 10   unsigned remainder magnitude (registered)
//     busy         out  1   high in RUN and DONE
//     done         out  1   one-cycle pulse, results valid
//     div_by_zero  out  1   divisor magnitude was zero (held until next done)
//     overflow     out  1   raw quotient exceeded 10 bits (held until next done)
// ---------------------------------------------------------------------------
module sm_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [20:0] Dividend,
   input  logic [10:0] Divisor,
   output logic [10:0] Quotient,
   output logic [9:0]  Remainder,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic        overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [19:0] dvd_sh;   // dividend bits still to be consumed, MSB first
   logic [19:0] quo;      // raw quotient bits gathered so far
   logic [9:0]  rem;      // partial remainder
   logic [9:0]  dvs;      // latched divisor magnitude
   logic        q_sign;   // latched sign of the quotient
   logic [4:0]  count;    // iteration index, 0..19

   logic        zero_dvs;
   logic        last_iter;

   logic [10:0] trial;
   logic [10:0] diff;
   logic        q_bit;
   logic [9:0]  rem_next;
   logic [19:0] quo_next;
   logic        ovf_raw;
   logic [9:0]  q_mag;

   assign zero_dvs  = (Divisor[9:0] == '0);
   assign last_iter = (count == 5'd19);

   // One restoring step. When the trial subtraction fails, trial is below
   // the divisor, so its top bit is zero and the low 10 bits are exact.
   always_comb begin
      trial    = {rem, dvd_sh[19]};
      diff     = trial - {1'b0, dvs};
      q_bit    = (trial >= {1'b0, dvs});
      rem_next = q_bit ? diff[9:0] : trial[9:0];
      quo_next = {quo[18:0], q_bit};
   end

   // The final step's bits are used directly, so the results register on
   // the same edge as the 20th iteration.
   always_comb begin
      ovf_raw = |quo_next[19:10];
`ifdef DIV_SATURATE_EN
      q_mag   = ovf_raw ? '1 : quo_next[9:0];
`else
      q_mag   = quo_next[9:0];
`endif
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start)
               state_next = zero_dvs ? DONE : RUN;
         end
         RUN: begin
            if (last_iter)
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_sh      <= '0;
         quo         <= '0;
         rem         <= '0;
         dvs         <= '0;
         q_sign      <= 1'b0;
         count       <= '0;
         Quotient    <= '0;
         Remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (zero_dvs) begin
                     Quotient    <= {Dividend[20] ^ Divisor[10], 10'h3FF};
                     Remainder   <= '0;
                     div_by_zero <= 1'b1;
                     overflow    <= 1'b0;
                  end else begin
                     dvd_sh <= Dividend[19:0];
                     dvs    <= Divisor[9:0];
                     q_sign <= Dividend[20] ^ Divisor[10];
                     rem    <= '0;
                     quo    <= '0;
                     count  <= '0;
                  end
               end
            end
            RUN: begin
               dvd_sh <= {dvd_sh[18:0], 1'b0};
               rem    <= rem_next;
               quo    <= quo_next;
               count  <= count + 5'd1;
               if (last_iter) begin
                  // A zero magnitude never carries a sign.
                  Quotient    <= {q_sign & (q_mag != '0), q_mag};
                  Remainder   <= rem_next;
                  div_by_zero <= 1'b0;
                  overflow    <= ovf_raw;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
